xbus_arb: RTL and testbench
===========================

# xbus_arb

Two-master arbiter for the shared data bus (data memory, register file and internal registers). Master 0 is the instruction controller's load/store port; master 1 is a host/DMA loader port. The arbiter grants one owner at a time with round-robin fairness, supports locked read-modify-write sequences, and bounds ownership with a hold counter. It routes the single-cycle-latency slave read data back to the master that issued the read.

## Interface
Parameters:
- ADDR_W, default `ADDR_W (xdefs.vh): bus address width
- DATA_W, default `DATA_W (xdefs.vh): bus data width
- MAX_HOLD, default 16: maximum consecutive granted cycles while the other master waits; must be ≥ 2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- m0_req / m1_req  in  1  master requests a transfer this cycle
- m0_lock / m1_lock  in  1  keep the grant while the request is held (read-modify-write)
- m0_we / m1_we  in  1  write when high, read when low
- m0_addr / m1_addr  in  ADDR_W  transfer address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_gnt / m1_gnt  out  1  registered grant; a transfer occurs in any cycle where req && gnt
- m0_rvalid / m1_rvalid  out  1  read data valid, one cycle after that master's read transfer
- m0_rdata / m1_rdata  out  DATA_W  equals s_rdata, meaningful only when the matching rvalid is high
- s_sel  out  1  slave select = (m0_req & m0_gnt) | (m1_req & m1_gnt)
- s_we  out  1  owner's we, gated by s_sel
- s_addr  out  ADDR_W  owner's address; 0 when no owner
- s_wdata  out  DATA_W  owner's write data; 0 when no owner
- s_rdata  in  DATA_W  slave read data, valid the cycle after a read select

## Operation
- States: IDLE, G0, G1. m0_gnt = (state==G0); m1_gnt = (state==G1). The grants are never both high.
- s_* is a combinational mux from the owner, so a transfer issues in the same cycle the owner's req is high.
- `last` register (1 bit) records the last master granted. Reset value is 1, so master 0 wins the first tie.
- From IDLE:
  - only mX_req high → GX
  - both high → the master ≠ last
  - none → stay in IDLE
- In GX, the owner releases when any of these holds:
  - (a) mX_req is low
  - (b) the other master requests and mX_lock is low
  - (c) the other master requests and hold_cnt == MAX_HOLD-1; this applies even when lock is high
- On release, the next state is G(other) if the other master requests, else IDLE. There is no idle bubble on handover.
- On each entry to GX: last ← X.
- hold_cnt (width clog2(MAX_HOLD)):
  - cleared on every state change and in IDLE
  - increments each cycle the state is held while the other master requests
  - saturates at MAX_HOLD-1
- Read return: a read transfer by X in cycle N sets mX_rvalid=1 in cycle N+1 for exactly one cycle per read. Back-to-back reads give back-to-back rvalid. rvalid follows the issuer even if the grant changed in between.
- A request from a master without grant is ignored by the slave. That master must hold req until it sees gnt.

## Timing
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, last=1, hold_cnt=0
  - m0_gnt=m1_gnt=0, m0_rvalid=m1_rvalid=0
  - s_sel=s_we=0, s_addr=0, s_wdata=0
- Reset mid-read drops the pending rvalid; no rvalid appears after reset is released.
- Latency:
  - request in IDLE: gnt the next cycle, first transfer that cycle (req→transfer = 1 cycle)
  - held grant: one transfer per cycle
  - read data: +1 cycle
- Handover: last owner cycle N, new owner granted and transferring in N+1.
- Simultaneous release and new request: the decision uses only current-cycle req/lock/hold_cnt, with no combinational path from req to gnt.
- Starvation bound: a requesting master waits at most MAX_HOLD+1 cycles for its grant.

## Test plan
- Single master: m0 reads addr 0x10 with s_rdata=0xA5 → m0_gnt in cycle 1, s_sel/s_addr=0x10 in cycle 1, m0_rvalid=1 and m0_rdata=0xA5 in cycle 2; m1 signals stay 0.
- Tie after reset: m0_req and m1_req both rise in the same cycle, single transfers, then deassert → G0 first, G1 next cycle with no bubble. A repeated tie now goes to master 0 again because last=1.
- Lock: m1 holds req+lock for 8 cycles while m0 requests, MAX_HOLD=16 → m1 owns all 8 cycles, m0_gnt in cycle 9.
- Forced rotation: MAX_HOLD=4, m0 req+lock continuous, m1 requests → m0 keeps 4 cycles, then m1_gnt. m0 regains the grant once m1 drops req.
- Write passthrough: m1 writes 0x3C to addr 0x7 → s_sel=s_we=1, s_addr=0x7, s_wdata=0x3C for one cycle; no rvalid.
- Reset mid-operation: assert rst low during the cycle after an m0 read → gnt, rvalid and s_sel go 0 immediately. After release, IDLE, and the next tie goes to master 0.

Source files
------------

// File: rtl/xbus_arb.sv
// xbus_arb: two-master round-robin arbiter for the shared data bus, with
// locked read-modify-write support, bounded ownership and read-data return.
`ifndef ADDR_W
`define ADDR_W 16
`endif
`ifndef DATA_W
`define DATA_W 16
`endif

module xbus_arb #(
   parameter int unsigned ADDR_W   = `ADDR_W,
   parameter int unsigned DATA_W   = `DATA_W,
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_lock,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_lock,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              s_sel,
   output logic              s_we,
   output logic [ADDR_W-1:0] s_addr,
   output logic [DATA_W-1:0] s_wdata,
   input  logic [DATA_W-1:0] s_rdata
);

   localparam int unsigned       HOLD_W    = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last;
   logic [HOLD_W-1:0] hold_cnt;
   logic              hold_max;
   logic              other_req;

   // Limit reached: a waiting master takes over even from a locked owner.
   assign hold_max  = (hold_cnt == HOLD_LAST);
   assign other_req = (state == G0) ? m1_req : m0_req;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state: round-robin on ties, release on drop / contention / hold limit.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_req && m1_req) state_nxt = last ? G0 : G1;
            else if (m0_req)      state_nxt = G0;
            else if (m1_req)      state_nxt = G1;
         end
         G0: begin
            if (!m0_req || (m1_req && (!m0_lock || hold_max)))
               state_nxt = m1_req ? G1 : IDLE;
         end
         G1: begin
            if (!m1_req || (m0_req && (!m1_lock || hold_max)))
               state_nxt = m0_req ? G0 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: grant decode and combinational slave mux from the owner.
   always_comb begin
      m0_gnt   = 1'b0;
      m1_gnt   = 1'b0;
      s_sel    = 1'b0;
      s_we     = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      m0_rdata = s_rdata;
      m1_rdata = s_rdata;
      case (state)
         G0: begin
            m0_gnt  = 1'b1;
            s_sel   = m0_req;
            s_we    = m0_req & m0_we;
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
         end
         G1: begin
            m1_gnt  = 1'b1;
            s_sel   = m1_req;
            s_we    = m1_req & m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
         end
         default: ;
      endcase
   end

   // Remember the most recently granted master for tie-breaking.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               last <= 1'b1;
      else if (state_nxt == G0 && state != G0) last <= 1'b0;
      else if (state_nxt == G1 && state != G1) last <= 1'b1;
   end

   // Count cycles the owner keeps the bus while the other master waits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     hold_cnt <= '0;
      else if (state == IDLE || state_nxt != state) hold_cnt <= '0;
      else if (other_req && !hold_max)              hold_cnt <= hold_cnt + HOLD_W'(1);
   end

   // Read return follows the issuer, one cycle after the read transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
      end else begin
         m0_rvalid <= m0_req & m0_gnt & ~m0_we;
         m1_rvalid <= m1_req & m1_gnt & ~m1_we;
      end
   end

endmodule

// File: tb/tb_xbus_arb.sv
// tb_xbus_arb: directed vectors plus randomized traffic against a behavioural
// arbitration model, on two instances (MAX_HOLD = 4 and 16) sharing inputs.
module tb_xbus_arb;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req = '0, lock = '0, we = '0;
   logic [AW-1:0] addr [2] = '{8'h0, 8'h0};
   logic [DW-1:0] wdata [2] = '{8'h0, 8'h0};
   logic [DW-1:0] srd = '0;

   // instance a: MAX_HOLD=4, instance b: MAX_HOLD=16
   logic g0_a, g1_a, rv0_a, rv1_a, sel_a, we_a;
   logic g0_b, g1_b, rv0_b, rv1_b, sel_b, we_b;
   logic [DW-1:0] rd0_a, rd1_a, wd_a, rd0_b, rd1_b, wd_b;
   logic [AW-1:0] ad_a, ad_b;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   xbus_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rst(rst_n),
      .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
      .m0_gnt(g0_a), .m0_rvalid(rv0_a), .m0_rdata(rd0_a),
      .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
      .m1_gnt(g1_a), .m1_rvalid(rv1_a), .m1_rdata(rd1_a),
      .s_sel(sel_a), .s_we(we_a), .s_addr(ad_a), .s_wdata(wd_a), .s_rdata(srd));

   xbus_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(16)) dut_b (
      .clk(clk), .rst(rst_n),
      .m0_req(req[0]), .m0_lock(lock[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
      .m0_gnt(g0_b), .m0_rvalid(rv0_b), .m0_rdata(rd0_b),
      .m1_req(req[1]), .m1_lock(lock[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
      .m1_gnt(g1_b), .m1_rvalid(rv1_b), .m1_rdata(rd1_b),
      .s_sel(sel_b), .s_we(we_b), .s_addr(ad_b), .s_wdata(wd_b), .s_rdata(srd));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // owner: -1 none, else master index; held: cycles kept while other waited
   int owner [2] = '{-1, -1};
   int last_g [2] = '{1, 1};
   int held [2] = '{0, 0};
   int mh [2] = '{4, 16};
   bit pend [2][2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         int o, oth, nx;
         if (!rst_n) begin
            owner[k] = -1; last_g[k] = 1; held[k] = 0;
            pend[k][0] = 1'b0; pend[k][1] = 1'b0;
         end else begin
            o = owner[k];
            for (int i = 0; i < 2; i++) pend[k][i] = (o == i) && req[i] && !we[i];
            if (o < 0) begin
               if (req[0] && req[1]) nx = 1 - last_g[k];
               else if (req[0])      nx = 0;
               else if (req[1])      nx = 1;
               else                  nx = -1;
            end else begin
               oth = 1 - o;
               if (req[o] && !(req[oth] && (!lock[o] || held[k] >= mh[k] - 1))) begin
                  nx = o;
                  if (req[oth]) held[k] = held[k] + 1;
               end else begin
                  nx = req[oth] ? oth : -1;
               end
            end
            if (nx != o) begin
               held[k] = 0;
               if (nx >= 0) last_g[k] = nx;
            end
            owner[k] = nx;
         end
      end
   end

   task automatic cmp_dut(input string nm, input int k, input logic g0, g1, rv0, rv1,
                          input logic [DW-1:0] rd0, rd1, input logic sel, swe,
                          input logic [AW-1:0] sad, input logic [DW-1:0] swd);
      int o;
      logic esel;
      o = owner[k];
      esel = (o >= 0) && req[o];
      chk({nm, "_gnt"}, 32'({g1, g0}), 32'({o == 1, o == 0}));
      chk({nm, "_rvalid"}, 32'({rv1, rv0}), 32'({pend[k][1], pend[k][0]}));
      chk({nm, "_sel"}, 32'(sel), 32'(esel));
      chk({nm, "_we"}, 32'(swe), 32'(esel && we[o]));
      chk({nm, "_addr"}, 32'(sad), (o >= 0) ? 32'(addr[o]) : 32'd0);
      chk({nm, "_wdata"}, 32'(swd), (o >= 0) ? 32'(wdata[o]) : 32'd0);
      if (pend[k][0]) chk({nm, "_rdata0"}, 32'(rd0), 32'(srd));
      if (pend[k][1]) chk({nm, "_rdata1"}, 32'(rd1), 32'(srd));
   endtask

   always @(negedge clk) begin
      cmp_dut("mdl_h4", 0, g0_a, g1_a, rv0_a, rv1_a, rd0_a, rd1_a, sel_a, we_a, ad_a, wd_a);
      cmp_dut("mdl_h16", 1, g0_b, g1_b, rv0_b, rv1_b, rd0_b, rd1_b, sel_b, we_b, ad_b, wd_b);
   end

   // ---------------- directed vectors (checked on the MAX_HOLD=16 instance) ----------------
   typedef struct {
      logic          rst_n;
      logic [1:0]    req, lock, we;
      logic [7:0]    a0, wd0, a1, wd1, srd;
      logic [1:0]    gnt, rv;
      logic          sel, swe;
      logic [7:0]    sad, swd, rd;
   } vec_t;

   vec_t tv [$];

   function automatic vec_t mk(input logic r, input logic [1:0] rq, lk, w,
                               input logic [7:0] a0, wd0, a1, wd1, sd,
                               input logic [1:0] g, rv, input logic s, sw,
                               input logic [7:0] sa, swd, rd);
      vec_t v;
      v.rst_n = r; v.req = rq; v.lock = lk; v.we = w;
      v.a0 = a0; v.wd0 = wd0; v.a1 = a1; v.wd1 = wd1; v.srd = sd;
      v.gnt = g; v.rv = rv; v.sel = s; v.swe = sw; v.sad = sa; v.swd = swd; v.rd = rd;
      return v;
   endfunction

   task automatic drive(input logic r, input logic [1:0] rq, lk, w,
                        input logic [7:0] a0, wd0, a1, wd1, sd);
      rst_n = r; req = rq; lock = lk; we = w;
      addr[0] = a0; wdata[0] = wd0; addr[1] = a1; wdata[1] = wd1; srd = sd;
   endtask

   initial begin
      // reset, single m0 read
      tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1, 0, 8'h10, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 2'b01, 2'b01, 0, 0, 8'h00, 8'h00, 8'hA5));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      // reset, tie twice: m0 then m1 without bubble, then m0 again
      tv.push_back(mk(0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b11, 8'h21, 8'h40, 8'h31, 8'h41, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b11, 8'h21, 8'h40, 8'h31, 8'h41, 8'h00, 2'b01, 2'b00, 1, 1, 8'h21, 8'h40, 8'h00));
      tv.push_back(mk(1, 2'b10, 2'b00, 2'b11, 8'h00, 8'h00, 8'h31, 8'h41, 8'h00, 2'b10, 2'b00, 1, 1, 8'h31, 8'h41, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b11, 8'h22, 8'h42, 8'h32, 8'h43, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b11, 2'b00, 2'b11, 8'h22, 8'h42, 8'h32, 8'h43, 8'h00, 2'b01, 2'b00, 1, 1, 8'h22, 8'h42, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      // m1 locked for 8 request cycles while m0 waits
      tv.push_back(mk(1, 2'b10, 2'b10, 2'b11, 8'h00, 8'h00, 8'h50, 8'h51, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      for (int i = 0; i < 7; i++)
         tv.push_back(mk(1, 2'b11, 2'b10, 2'b11, 8'h60, 8'h61, 8'h50, 8'h51, 8'h00, 2'b10, 2'b00, 1, 1, 8'h50, 8'h51, 8'h00));
      tv.push_back(mk(1, 2'b01, 2'b00, 2'b11, 8'h60, 8'h61, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b01, 2'b00, 2'b11, 8'h60, 8'h61, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 1, 1, 8'h60, 8'h61, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      // m1 write passthrough, then m1 read return
      tv.push_back(mk(1, 2'b10, 2'b00, 2'b10, 8'h00, 8'h00, 8'h07, 8'h3C, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b10, 2'b00, 2'b10, 8'h00, 8'h00, 8'h07, 8'h3C, 8'h00, 2'b10, 2'b00, 1, 1, 8'h07, 8'h3C, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h00, 8'h33, 8'h00, 8'h00, 2'b10, 2'b00, 1, 0, 8'h33, 8'h00, 8'h00));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 2'b10, 2'b10, 0, 0, 8'h00, 8'h00, 8'h5A));
      tv.push_back(mk(1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));

      for (int i = 0; i < tv.size(); i++) begin
         @(posedge clk); #1;
         drive(tv[i].rst_n, tv[i].req, tv[i].lock, tv[i].we, tv[i].a0, tv[i].wd0, tv[i].a1, tv[i].wd1, tv[i].srd);
         @(negedge clk);
         chk($sformatf("vec%0d_gnt", i), 32'({g1_b, g0_b}), 32'(tv[i].gnt));
         chk($sformatf("vec%0d_rvalid", i), 32'({rv1_b, rv0_b}), 32'(tv[i].rv));
         chk($sformatf("vec%0d_sel_we", i), 32'({sel_b, we_b}), 32'({tv[i].sel, tv[i].swe}));
         chk($sformatf("vec%0d_addr_wdata", i), 32'({ad_b, wd_b}), 32'({tv[i].sad, tv[i].swd}));
         if (tv[i].rv[0]) chk($sformatf("vec%0d_rdata0", i), 32'(rd0_b), 32'(tv[i].rd));
         if (tv[i].rv[1]) chk($sformatf("vec%0d_rdata1", i), 32'(rd1_b), 32'(tv[i].rd));
      end

      // forced rotation: m0 locked; MAX_HOLD=4 yields after 4 cycles, 16 does not
      for (int c = 0; c <= 6; c++) begin
         @(posedge clk); #1;
         drive(1'b1, {(c >= 1 && c <= 5), 1'b1}, 2'b01, 2'b11, 8'h44, 8'h45, 8'h54, 8'h55, 8'h00);
         @(negedge clk);
         if (c >= 1) begin
            chk($sformatf("rot_h4_c%0d", c), 32'({g1_a, g0_a}), (c == 5) ? 32'd2 : 32'd1);
            chk($sformatf("rot_h16_c%0d", c), 32'({g1_b, g0_b}), 32'd1);
         end
      end
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      end

      // reset in the cycle after an m0 read drops everything immediately
      @(posedge clk); #1;
      drive(1'b1, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid_pre_gnt", 32'({g0_b, sel_b}), 32'd3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstmid_pre_rvalid", 32'(rv0_b), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_gnt", 32'({g1_b, g0_b}), 32'd0);
      chk("rstmid_rvalid", 32'({rv1_b, rv0_b}), 32'd0);
      chk("rstmid_sel", 32'(sel_b), 32'd0);
      @(posedge clk); #1;
      drive(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      chk("rstpost_rvalid", 32'({rv1_b, rv0_b}), 32'd0);
      @(posedge clk); #1;
      drive(1'b1, 2'b11, 2'b00, 2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00);
      @(negedge clk);
      chk("rstpost_idle", 32'({g1_b, g0_b}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstpost_tie_m0", 32'({g1_b, g0_b}), 32'd1);

      // randomized traffic; masters hold req until granted (tracked on instance a)
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #1;
         for (int i = 0; i < 2; i++) begin
            logic g;
            g = (i == 0) ? g0_a : g1_a;
            if (req[i] && !g)  req[i] = 1'b1;
            else if (req[i])   req[i] = ($urandom_range(0, 99) < 85);
            else               req[i] = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 9) == 0) lock[i] = ~lock[i];
            we[i]    = 1'($urandom_range(0, 1));
            addr[i]  = AW'($urandom);
            wdata[i] = DW'($urandom);
         end
         srd   = DW'($urandom);
         rst_n = ($urandom_range(0, 499) != 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
